// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative logarithmic shifter: op codes, FSM states
// and the stage count.
package shifter_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [1:0] OP_ROTR = 2'b10;

    localparam int         NUM_STAGES = 5;
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One binary stage of the shifter: moves the value by 2**i_exp according to
// the op, or passes it through when disabled.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [1:0]       i_op,
    input  logic             i_en,
    input  logic [2:0]       i_exp,
    output logic [WIDTH-1:0] o_value
);

    logic [4:0]       w_dist;
    logic [5:0]       w_rdist;
    logic [WIDTH-1:0] w_shifted;

    assign w_dist  = 5'd1 << i_exp;
    // Distance is always 1..16, so the complementary rotate amount stays in range.
    assign w_rdist = 6'(WIDTH) - {1'b0, w_dist};

    always_comb begin
        w_shifted = i_value;
        case (i_op)
            OP_SLL:  w_shifted = i_value << w_dist;
            OP_SRL:  w_shifted = i_value >> w_dist;
            OP_SRA:  w_shifted = $signed(i_value) >>> w_dist;
            OP_ROTR: w_shifted = (i_value >> w_dist) | (i_value << w_rdist);
            default: w_shifted = i_value;
        endcase
    end

    assign o_value = i_en ? w_shifted : i_value;

endmodule

// File: rtl/shamt_seq_shifter.sv
// Iterative shifter: narrows the 32-bit shift amount to 5 bits and applies one
// binary stage (16, 8, 4, 2, 1) per clock, publishing the result on oDone.
module shamt_seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iData,
    input  logic [WIDTH-1:0] iShamt,
    output logic [WIDTH-1:0] oData,
    output logic             oReady,
    output logic             oBusy,
    output logic             oDone,
    output logic [1:0]       oDbgState
);

    // Handshake: a request is taken when iStart=1 and oReady=1 at a rising edge;
    // oDone pulses for one cycle with oData valid; iStart is ignored while oBusy=1.

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_work;
    logic [SHAMT_W-1:0]   r_amt;
    logic [1:0]           r_op;
    logic [2:0]           r_cnt;
    logic [WIDTH-1:0]     r_data;

    logic                 w_capture;
    logic                 w_advance;
    logic                 w_finish;
    logic [2:0]           w_exp;
    logic                 w_en;
    logic [WIDTH-1:0]     w_stage_out;
    logic                 w_unused_shamt;

    assign w_unused_shamt = ^iShamt[WIDTH-1:SHAMT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_advance = 1'b1;
                if (r_cnt == LAST_STAGE) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iStart) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Counter k selects distance 2**(4-k) and amount bit 4-k.
    assign w_exp = LAST_STAGE - r_cnt;
    assign w_en  = r_amt[w_exp];

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_value (r_work),
        .i_op    (r_op),
        .i_en    (w_en),
        .i_exp   (w_exp),
        .o_value (w_stage_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_amt  <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if (w_capture) begin
                r_work <= iData;
                r_amt  <= iShamt[SHAMT_W-1:0];
                r_op   <= iOp;
                r_cnt  <= '0;
            end else if (w_advance) begin
                r_work <= w_stage_out;
                if (!w_finish) begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
            if (w_finish) begin
                r_data <= w_stage_out;
            end
        end
    end

    assign oData     = r_data;
    assign oReady    = (r_state != ST_SHIFT);
    assign oBusy     = (r_state == ST_SHIFT);
    assign oDone     = (r_state == ST_DONE);
    assign oDbgState = r_state;

endmodule
